// File: rtl/mni_pkt_sequencer.sv
// rtl/mni_pkt_sequencer.sv - sequences decoded RX packets onto the myNodeInfo input buses
// Registers one packet, holds it for a setup window, pulses en_MNI, then waits out MNI latency.
module mni_pkt_sequencer #(
    parameter int SETUP_CYC     = 2,
    parameter int MNI_LAT       = 3,
    parameter int ROUND_TIMEOUT = 1000,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_valid,
    output logic             pkt_ready,
    input  logic [2:0]       pkt_type,
    input  logic [15:0]      pkt_hops,
    input  logic [15:0]      pkt_e_max,
    input  logic [15:0]      pkt_e_min,
    input  logic [15:0]      pkt_energy,
    input  logic [15:0]      pkt_e_thresh,
    input  logic [15:0]      pkt_ch_id,
    input  logic [15:0]      pkt_timeslot,
    output logic             en_MNI,
    output logic [2:0]       fPktType,
    output logic [15:0]      hops,
    output logic [15:0]      e_max,
    output logic [15:0]      e_min,
    output logic [15:0]      energy,
    output logic [15:0]      e_threshold,
    output logic [15:0]      ch_ID,
    output logic [15:0]      timeslot,
    output logic             busy,
    output logic [CNT_W-1:0] fwd_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             round_timeout
);

    localparam int PH_MAX = (SETUP_CYC > MNI_LAT) ? SETUP_CYC : MNI_LAT;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TMR_W  = $clog2(ROUND_TIMEOUT + 1);

    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0]  WAIT_LAST  = PH_W'(MNI_LAT - 1);
    localparam logic [TMR_W-1:0] TMR_END    = TMR_W'(ROUND_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SETUP, FIRE, WAIT} state_t;

    state_t           state, state_nx;
    logic [PH_W-1:0]  phase;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nx;
    logic             tmr_run;
    logic             take;
    logic             fwd_type;

    assign fwd_type = (pkt_type == 3'b000) || (pkt_type == 3'b001);
    assign busy     = (state != IDLE);
    assign tmr_nx   = tmr + TMR_W'(1);

    always_comb begin
        state_nx  = state;
        pkt_ready = 1'b0;
        en_MNI    = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    take = 1'b1;
                    if (fwd_type) state_nx = SETUP;
                end
            end
            SETUP: if (phase == SETUP_LAST) state_nx = FIRE;
            FIRE: begin
                en_MNI   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (phase == WAIT_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // phase restarts on every state change so SETUP and WAIT each count from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_nx;
            phase <= (state_nx != state) ? '0 : phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fPktType    <= 3'b111;
            hops        <= '0;
            e_max       <= '0;
            e_min       <= '0;
            energy      <= '0;
            e_threshold <= '0;
            ch_ID       <= '0;
            timeslot    <= '0;
        end else if (take && fwd_type) begin
            fPktType    <= pkt_type;
            hops        <= pkt_hops;
            e_max       <= pkt_e_max;
            e_min       <= pkt_e_min;
            energy      <= pkt_energy;
            e_threshold <= pkt_e_thresh;
            ch_ID       <= pkt_ch_id;
            timeslot    <= pkt_timeslot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (en_MNI && fwd_cnt != CNT_MAX) fwd_cnt <= fwd_cnt + CNT_W'(1);
            if (take && !fwd_type && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // fPktType is stable through FIRE, so it identifies which packet is firing
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr           <= '0;
            tmr_run       <= 1'b0;
            round_timeout <= 1'b0;
        end else if (en_MNI && fPktType == 3'b000) begin
            tmr           <= '0;
            tmr_run       <= 1'b1;
            round_timeout <= 1'b0;
        end else if (en_MNI && fPktType == 3'b001) begin
            tmr     <= '0;
            tmr_run <= 1'b0;
        end else if (tmr_run) begin
            tmr <= tmr_nx;
            if (tmr_nx == TMR_END) begin
                round_timeout <= 1'b1;
                tmr_run       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mni_pkt_sequencer.sv
// tb/tb_mni_pkt_sequencer.sv - scoreboard bench for mni_pkt_sequencer
module tb_mni_pkt_sequencer;

    localparam int SETUP_CYC = 2;
    localparam int MNI_LAT   = 3;
    localparam int RTO       = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [2:0]  pkt_type = 3'b000;
    logic [15:0] pkt_hops = '0, pkt_e_max = '0, pkt_e_min = '0, pkt_energy = '0;
    logic [15:0] pkt_e_thresh = '0, pkt_ch_id = '0, pkt_timeslot = '0;
    logic        en_MNI;
    logic [2:0]  fPktType;
    logic [15:0] hops, e_max, e_min, energy, e_threshold, ch_ID, timeslot;
    logic        busy;
    logic [7:0]  fwd_cnt, drop_cnt;
    logic        round_timeout;

    mni_pkt_sequencer #(
        .SETUP_CYC(SETUP_CYC), .MNI_LAT(MNI_LAT), .ROUND_TIMEOUT(RTO), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_type(pkt_type), .pkt_hops(pkt_hops), .pkt_e_max(pkt_e_max),
        .pkt_e_min(pkt_e_min), .pkt_energy(pkt_energy), .pkt_e_thresh(pkt_e_thresh),
        .pkt_ch_id(pkt_ch_id), .pkt_timeslot(pkt_timeslot), .en_MNI(en_MNI),
        .fPktType(fPktType), .hops(hops), .e_max(e_max), .e_min(e_min), .energy(energy),
        .e_threshold(e_threshold), .ch_ID(ch_ID), .timeslot(timeslot), .busy(busy),
        .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt), .round_timeout(round_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        logic [2:0]  typ;
        logic [111:0] flds;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every en_MNI pulse must match the oldest expected forward.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && en_MNI) begin
                if (q.size() == 0) begin
                    chk("unexpected_en_MNI", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("en_cycle", cyc, e.cyc);
                    chk("fPktType", fPktType, e.typ);
                    chk("fields", {hops, e_max, e_min, energy, e_threshold, ch_ID, timeslot}, e.flds);
                end
            end
        end
    end

    task automatic wait_until(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc < target && n < 5000);
        if (cyc < target) chk("wait_timeout", cyc, target);
    endtask

    task automatic send(input logic [2:0] t, input logic [15:0] h, em, en, eg, et, ci, ts,
                        input bit fire, input bit align, output int hc);
        int n;
        exp_t e;
        if (align) begin
            @(posedge clk);
            #1;
        end
        pkt_type = t; pkt_hops = h; pkt_e_max = em; pkt_e_min = en; pkt_energy = eg;
        pkt_e_thresh = et; pkt_ch_id = ci; pkt_timeslot = ts; pkt_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (pkt_ready) break;
        end
        if (n == 50) chk("accept_timeout", 0, 1);
        hc = cyc;
        if (fire) begin
            e.cyc  = hc + 1 + SETUP_CYC;
            e.typ  = t;
            e.flds = {h, em, en, eg, et, ci, ts};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h, h2, hc, f;
        // 1: reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_en_MNI", en_MNI, 0);
        chk("rst_fPktType", fPktType, 3'b111);
        chk("rst_busy", busy, 0);
        chk("rst_fwd_cnt", fwd_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_pkt_ready", pkt_ready, 1);
        chk("rst_hops", hops, 0);
        chk("rst_round_timeout", round_timeout, 0);

        // 2: HB forward timing
        send(3'b000, 16'h0001, 16'h8000, 16'h4000, 16'h8000, 16'h3333, 16'h0000, 16'h0000, 1, 1, h);
        wait_until(h + 1);
        chk("hb_hops_n1", hops, 16'h0001);
        chk("hb_thresh_n1", e_threshold, 16'h3333);
        chk("hb_ready_setup", pkt_ready, 0);
        wait_until(h + 6);
        chk("hb_busy_n6", busy, 1);
        chk("hb_fwd_cnt", fwd_cnt, 1);
        wait_until(h + 7);
        chk("hb_busy_n7", busy, 0);

        // 3: back-to-back drops
        send(3'b010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'd32, 16'h0, 0, 1, h);
        send(3'b111, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, h2);
        chk("drop_b2b", h2, h + 1);
        wait_until(h2 + 1);
        chk("drop_cnt_2", drop_cnt, 2);
        chk("drop_type_kept", fPktType, 3'b000);
        chk("drop_chid_kept", ch_ID, 16'h0000);
        chk("drop_busy", busy, 0);

        // 4: HB then CHE held valid during busy
        send(3'b000, 16'h0002, 16'h0100, 16'h0010, 16'h0080, 16'h0040, 16'h0000, 16'h0000, 1, 1, h);
        send(3'b001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h000C, 16'h0005, 1, 0, hc);
        chk("che_accept_cycle", hc, h + SETUP_CYC + MNI_LAT + 2);
        wait_until(hc + 4);
        chk("che_fwd_cnt", fwd_cnt, 3);
        chk("che_rt_after", round_timeout, 0);
        wait_until(hc + 30);
        chk("che_rt_stopped", round_timeout, 0);

        // 5: HB with no CHE
        send(3'b000, 16'h0003, 16'h0200, 16'h0020, 16'h0100, 16'h0050, 16'h0000, 16'h0000, 1, 1, h);
        f = h + 1 + SETUP_CYC;
        wait_until(f + RTO - 1);
        chk("rt_before", round_timeout, 0);
        wait_until(f + RTO + 1);
        chk("rt_set", round_timeout, 1);
        wait_until(f + RTO + 20);
        chk("rt_sticky", round_timeout, 1);
        send(3'b000, 16'h0004, 16'h0300, 16'h0030, 16'h0200, 16'h0060, 16'h0000, 16'h0000, 1, 1, h);
        wait_until(h + 1 + SETUP_CYC);
        chk("rt_hold_fire", round_timeout, 1);
        wait_until(h + 2 + SETUP_CYC);
        chk("rt_clear_hb", round_timeout, 0);
        chk("fwd_cnt_5", fwd_cnt, 5);
        wait_until(h + 8);

        // 6: reset in SETUP, then saturating drops
        send(3'b000, 16'h0005, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0000, 16'h0000, 0, 1, h);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_until(h + 2);
        chk("abort_busy", busy, 0);
        chk("abort_type", fPktType, 3'b111);
        chk("abort_hops", hops, 0);
        chk("abort_fwd_cnt", fwd_cnt, 0);
        wait_until(h + 8);
        for (int i = 0; i < 300; i++)
            send(3'b010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, (i == 0), hc);
        wait_until(hc + 1);
        chk("drop_sat", drop_cnt, 8'hFF);
        chk("drop_sat_fwd", fwd_cnt, 0);

        repeat (10) @(negedge clk);
        while (q.size() != 0) begin
            chk("missing_en_MNI", q.size(), 0);
            void'(q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
